// File: rtl/bus_tx_pkg.sv
// Shared types and defaults for the bus transmit sequencer slice.
package bus_tx_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_TURNAROUND = 1;
  localparam int unsigned DEF_MAX_BURST  = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    DRIVE,
    RELEASE
  } state_t;

  // Occupancy counter width: one extra bit so a full FIFO is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bus_tx_if.sv
// Producer, arbiter and tri-state driver signals of the bus transmit sequencer.
interface bus_tx_if
  import bus_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             bus_req;
  logic             bus_gnt;
  logic [WIDTH-1:0] data_bus_out;
  logic             drive_en;
  logic             busy;
  logic [CW-1:0]    fifo_count;

  modport master (
    input  wr_data, wr_valid, bus_gnt,
    output wr_ready, bus_req, data_bus_out, drive_en, busy, fifo_count
  );

  modport slave (
    output wr_data, wr_valid, bus_gnt,
    input  wr_ready, bus_req, data_bus_out, drive_en, busy, fifo_count
  );

endinterface

// File: rtl/bus_tx_fifo.sv
// Circular byte FIFO with registered count/full/empty; exposes head and the entry behind it.
module bus_tx_fifo
  import bus_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned CW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next_head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/bus_tx_sequencer.sv
// Buffers producer bytes, arbitrates for the shared bus and sequences data/enable
// for the tri-state driver with setup and hold turnaround around each burst.
module bus_tx_sequencer
  import bus_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned TURNAROUND = DEF_TURNAROUND,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input logic      clk,
  input logic      rst,
  bus_tx_if.master bus
);
  localparam int unsigned CW         = cnt_w(DEPTH);
  localparam logic [2:0]  TA_LAST    = 3'(TURNAROUND - 1);
  localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);

  state_t           state;
  logic [2:0]       ta_cnt;
  logic [7:0]       burst_cnt;
  logic             bus_req_q;
  logic             drive_en_q;
  logic             busy_q;
  logic [WIDTH-1:0] data_q;

  logic             pop_c;
  logic             last_byte_c;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] next_head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  assign pop_c = (state == DRIVE) && !empty;

  // Burst ends when this pop drains the FIFO, hits the burst limit, or the grant is gone.
  assign last_byte_c = (count == CW'(1)) || (burst_cnt == BURST_LAST) || !bus.bus_gnt;

  bus_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_valid),
    .push_data (bus.wr_data),
    .pop       (pop_c),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ta_cnt     <= '0;
      burst_cnt  <= '0;
      bus_req_q  <= 1'b0;
      drive_en_q <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= REQ;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        REQ: begin
          if (bus.bus_gnt) begin
            state     <= SETUP;
            data_q    <= head;
            ta_cnt    <= '0;
            burst_cnt <= '0;
          end
        end
        SETUP: begin
          if (!bus.bus_gnt) begin
            state     <= RELEASE;
            bus_req_q <= 1'b0;
            ta_cnt    <= '0;
          end else if (ta_cnt == TA_LAST) begin
            state      <= DRIVE;
            drive_en_q <= 1'b1;
          end else begin
            ta_cnt <= ta_cnt + 3'd1;
          end
        end
        DRIVE: begin
          // Data only advances while the burst continues; RELEASE holds the last byte.
          if (last_byte_c) begin
            state      <= RELEASE;
            drive_en_q <= 1'b0;
            bus_req_q  <= 1'b0;
            ta_cnt     <= '0;
          end else begin
            data_q    <= next_head;
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        RELEASE: begin
          if (ta_cnt == TA_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            ta_cnt <= ta_cnt + 3'd1;
          end
        end
        default: begin
          state      <= IDLE;
          bus_req_q  <= 1'b0;
          drive_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready     = !full;
  assign bus.fifo_count   = count;
  assign bus.bus_req      = bus_req_q;
  assign bus.drive_en     = drive_en_q;
  assign bus.busy         = busy_q;
  assign bus.data_bus_out = data_q;

endmodule
